mem_issue_scheduler: RTL and testbench
======================================

// Module: mem_issue_scheduler
// PURPOSE
// - Age-ordered issue queue sitting between rename/dispatch and the data-cache port; feeds memory ops into the mem buffer datapath.
// - Holds dispatched memory ops, wakes operands on write-back tag broadcast, issues one op at a time to the single D-cache port.
// - Ordering: loads may pass older loads, never an older unissued store; a store issues only as the oldest valid entry.
// PARAMETERS
// - DEPTH  4  queue entries, power of two, >= 2
// - RW     $clog2(`NUM_REG)  register tag width (derived, not overridable)
// PORTS
// - clk            in   1        clock; all state on rising edge
// - n_rst          in   1        asynchronous active-low reset
// - alloc_valid    in   1        dispatch offers one mem op
// - alloc_ready    out  1        queue not full; alloc accepted when valid&&ready
// - alloc_is_store in   1        1 = store, 0 = load
// - alloc_use_ra / alloc_ra_addr / alloc_ra_rdy   in 1/RW/1   operand A used, tag, already ready
// - alloc_use_rt / alloc_rt_addr / alloc_rt_rdy   in 1/RW/1   operand T used, tag, already ready
// - alloc_use_rw / alloc_rw_addr                  in 1/RW     destination used, tag
// - alloc_mem_op   in   MemOp    nand_cpu_pkg::MemOp
// - wb_valid / wb_addr           in 1/RW   write-back tag broadcast, one per cycle
// - flush          in   1        discard all queued and in-flight ops
// - dc_req_valid   out  1        request to D-cache
// - dc_req_ready   in   1        D-cache accepts request
// - dc_req_op      out  MemOp    op of issued entry
// - dc_req_ra_addr / dc_req_rt_addr / dc_req_rw_addr / dc_req_use_rw  out RW/RW/RW/1
// - dc_resp_valid  in   1        D-cache completion of the outstanding request
// - done_valid / done_rw_addr / done_use_rw  out 1/RW/1   1-cycle completion pulse
// - empty          out  1        no valid entries and FSM in IDLE
// BEHAVIOUR
// - Reset: all entries invalid, head=tail=count=0, FSM IDLE; alloc_ready=1, empty=1, dc_req_*=0, done_*=0.
// - Storage: ring of DEPTH slots; alloc writes slot tail, tail++ (wraps mod DEPTH), count++; full when count==DEPTH.
// - Operand ready bit = !use || alloc_*_rdy || (wb_valid && wb_addr==tag) in alloc cycle; thereafter set on any matching wb.
// - Eligible: valid && all used operands ready && (store: no older valid entry; load: no older valid store).
// - Age order from head toward tail; oldest eligible entry wins.
// - Head reclaim: if slot head invalid and count>0, head++ and count-- (one slot per cycle); simultaneous alloc keeps count net.
// - FSM IDLE: if eligible entry exists and no flush -> latch its fields into request regs, clear its valid, go REQ.
// - FSM REQ: dc_req_valid=1, request fields held stable; dc_req_ready -> WAIT.
// - FSM WAIT: dc_resp_valid -> done_valid=1 for one cycle with latched rw tag/use -> IDLE.
// - Latency: op allocated ready at cycle N -> selected at N+1 -> dc_req_valid at N+2; done one cycle after dc_resp_valid.
// - Exactly one op outstanding; dc_resp_valid outside WAIT/DRAIN ignored.
// - Flush (priority over alloc and select): all entries invalid, head=tail=count=0 next cycle; alloc in flush cycle dropped.
// - Flush in REQ: dc_req_valid low next cycle, -> IDLE. Flush in WAIT: -> DRAIN; DRAIN consumes dc_resp_valid with no done, -> IDLE.
// - Flush in the same cycle as dc_req_ready in REQ: request counts as accepted -> DRAIN.
// - Reset mid-operation: immediate return to reset state regardless of FSM state.
// CONFIGURATION
// - MEM_SCHED_PERF_CNT_EN defined: adds outputs perf_issue_cnt[31:0] (REQ->WAIT handshakes) and
//   perf_stall_cnt[31:0] (cycles in IDLE with count>0 and no eligible entry); both saturate at all-ones, reset to 0, not cleared by flush.
// - Undefined: these ports and counters do not exist; all other behaviour identical.
// TESTING (DEPTH=4)
// - Alloc 4 ready loads back-to-back -> alloc_ready=0 after 4th; each issues in age order, done pulses carry rw tags in order.
// - Store (ra not ready, tag 5) then ready load -> load held; wb_addr=5 -> store issues first, load issues after store done.
// - Load A (rt pending tag 7) then ready load B -> B issues first; wb tag 7 -> A issues next.
// - dc_req_ready held 0 for 10 cycles -> dc_req_valid and fields stable throughout, no second request.
// - Flush in WAIT with 3 queued -> empty queue next cycle; following dc_resp_valid yields no done_valid; empty=1 after.
// - alloc with alloc_ra_rdy=0 and same-cycle wb_addr==ra_addr -> issues at N+2 without further wb.

Source files
------------

// File: rtl/mem_issue_scheduler.sv
// Age-ordered memory-op issue queue feeding the single D-cache request port.
// Optional MEM_SCHED_PERF_CNT_EN adds saturating issue/stall performance counters.
`ifndef NUM_REG
`define NUM_REG 32
`endif

`ifndef NAND_CPU_PKG_DEFINED
`define NAND_CPU_PKG_DEFINED
package nand_cpu_pkg;
   typedef enum logic [2:0] {
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
   } MemOp;
endpackage
`endif

module mem_issue_scheduler #(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned RW = $clog2(`NUM_REG)
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                alloc_valid,
   output logic                alloc_ready,
   input  logic                alloc_is_store,
   input  logic                alloc_use_ra,
   input  logic [RW-1:0]       alloc_ra_addr,
   input  logic                alloc_ra_rdy,
   input  logic                alloc_use_rt,
   input  logic [RW-1:0]       alloc_rt_addr,
   input  logic                alloc_rt_rdy,
   input  logic                alloc_use_rw,
   input  logic [RW-1:0]       alloc_rw_addr,
   input  nand_cpu_pkg::MemOp  alloc_mem_op,
   input  logic                wb_valid,
   input  logic [RW-1:0]       wb_addr,
   input  logic                flush,
   output logic                dc_req_valid,
   input  logic                dc_req_ready,
   output nand_cpu_pkg::MemOp  dc_req_op,
   output logic [RW-1:0]       dc_req_ra_addr,
   output logic [RW-1:0]       dc_req_rt_addr,
   output logic [RW-1:0]       dc_req_rw_addr,
   output logic                dc_req_use_rw,
   input  logic                dc_resp_valid,
   output logic                done_valid,
   output logic [RW-1:0]       done_rw_addr,
   output logic                done_use_rw,
   output logic                empty
`ifdef MEM_SCHED_PERF_CNT_EN
   ,
   output logic [31:0]         perf_issue_cnt,
   output logic [31:0]         perf_stall_cnt
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
   state_t state, state_next;

   logic [DEPTH-1:0]   valid, is_store, ra_rdy, rt_rdy, use_rw;
   logic [RW-1:0]      ra_addr [DEPTH];
   logic [RW-1:0]      rt_addr [DEPTH];
   logic [RW-1:0]      rw_addr [DEPTH];
   nand_cpu_pkg::MemOp op      [DEPTH];

   logic [PW-1:0] head, tail;
   logic [PW:0]   count;

   logic          alloc_fire, reclaim, sel_found, select_fire, done_fire;
   logic [PW-1:0] sel_idx, slot;
   logic          older_valid, older_store;

   assign alloc_ready = (count != (PW+1)'(DEPTH));
   assign alloc_fire  = alloc_valid && alloc_ready && !flush;
   assign reclaim     = !valid[head] && (count != '0);
   assign empty       = (valid == '0) && (state == IDLE);

   // Walk from head toward tail; the first ready entry not blocked by an older op wins.
   always_comb begin
      sel_found   = 1'b0;
      sel_idx     = '0;
      slot        = '0;
      older_valid = 1'b0;
      older_store = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         slot = head + PW'(i);
         if (valid[slot]) begin
            if (!sel_found && ra_rdy[slot] && rt_rdy[slot] &&
                (is_store[slot] ? !older_valid : !older_store)) begin
               sel_found = 1'b1;
               sel_idx   = slot;
            end
            older_valid = 1'b1;
            older_store = older_store | is_store[slot];
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_next;
   end

   // A flush racing the response in WAIT has nothing left to drain.
   always_comb begin
      state_next   = state;
      select_fire  = 1'b0;
      done_fire    = 1'b0;
      dc_req_valid = 1'b0;
      case (state)
         IDLE: begin
            if (sel_found && !flush) begin
               select_fire = 1'b1;
               state_next  = REQ;
            end
         end
         REQ: begin
            dc_req_valid = 1'b1;
            if (flush)             state_next = dc_req_ready ? DRAIN : IDLE;
            else if (dc_req_ready) state_next = WAIT;
         end
         WAIT: begin
            if (flush) begin
               state_next = dc_resp_valid ? IDLE : DRAIN;
            end else if (dc_resp_valid) begin
               done_fire  = 1'b1;
               state_next = IDLE;
            end
         end
         DRAIN: begin
            if (dc_resp_valid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (reclaim)    head <= head + PW'(1);
         if (alloc_fire) tail <= tail + PW'(1);
         count <= count + (PW+1)'(alloc_fire) - (PW+1)'(reclaim);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         valid    <= '0;
         is_store <= '0;
         ra_rdy   <= '0;
         rt_rdy   <= '0;
         use_rw   <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            ra_addr[k] <= '0;
            rt_addr[k] <= '0;
            rw_addr[k] <= '0;
            op[k]      <= nand_cpu_pkg::MEM_LB;
         end
      end else begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (wb_valid && valid[k] && (wb_addr == ra_addr[k])) ra_rdy[k] <= 1'b1;
            if (wb_valid && valid[k] && (wb_addr == rt_addr[k])) rt_rdy[k] <= 1'b1;
         end
         if (flush) begin
            valid <= '0;
         end else begin
            if (select_fire) valid[sel_idx] <= 1'b0;
            if (alloc_fire) begin
               valid[tail]    <= 1'b1;
               is_store[tail] <= alloc_is_store;
               ra_addr[tail]  <= alloc_ra_addr;
               rt_addr[tail]  <= alloc_rt_addr;
               rw_addr[tail]  <= alloc_rw_addr;
               use_rw[tail]   <= alloc_use_rw;
               op[tail]       <= alloc_mem_op;
               ra_rdy[tail]   <= !alloc_use_ra || alloc_ra_rdy ||
                                 (wb_valid && (wb_addr == alloc_ra_addr));
               rt_rdy[tail]   <= !alloc_use_rt || alloc_rt_rdy ||
                                 (wb_valid && (wb_addr == alloc_rt_addr));
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         dc_req_op      <= nand_cpu_pkg::MEM_LB;
         dc_req_ra_addr <= '0;
         dc_req_rt_addr <= '0;
         dc_req_rw_addr <= '0;
         dc_req_use_rw  <= 1'b0;
      end else if (select_fire) begin
         dc_req_op      <= op[sel_idx];
         dc_req_ra_addr <= ra_addr[sel_idx];
         dc_req_rt_addr <= rt_addr[sel_idx];
         dc_req_rw_addr <= rw_addr[sel_idx];
         dc_req_use_rw  <= use_rw[sel_idx];
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         done_valid   <= 1'b0;
         done_rw_addr <= '0;
         done_use_rw  <= 1'b0;
      end else begin
         done_valid <= done_fire;
         if (done_fire) begin
            done_rw_addr <= dc_req_rw_addr;
            done_use_rw  <= dc_req_use_rw;
         end
      end
   end

`ifdef MEM_SCHED_PERF_CNT_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if ((state == REQ) && dc_req_ready && (perf_issue_cnt != '1))
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
         if ((state == IDLE) && (count != '0) && !sel_found && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_issue_scheduler.sv
// Self-checking bench for mem_issue_scheduler: directed scenarios plus a
// randomized run compared against a queue-based reference model.
`ifndef NUM_REG
`define NUM_REG 32
`endif

module tb_mem_issue_scheduler;
   import nand_cpu_pkg::*;

   localparam int DEPTH = 4;
   localparam int RW    = $clog2(`NUM_REG);

   logic          clk = 1'b0;
   logic          n_rst;
   logic          alloc_valid, alloc_ready, alloc_is_store;
   logic          alloc_use_ra, alloc_ra_rdy, alloc_use_rt, alloc_rt_rdy, alloc_use_rw;
   logic [RW-1:0] alloc_ra_addr, alloc_rt_addr, alloc_rw_addr;
   MemOp          alloc_mem_op;
   logic          wb_valid;
   logic [RW-1:0] wb_addr;
   logic          flush;
   logic          dc_req_valid, dc_req_ready, dc_req_use_rw;
   MemOp          dc_req_op;
   logic [RW-1:0] dc_req_ra_addr, dc_req_rt_addr, dc_req_rw_addr;
   logic          dc_resp_valid;
   logic          done_valid, done_use_rw;
   logic [RW-1:0] done_rw_addr;
   logic          empty;

   int total = 0;
   int bad   = 0;

   mem_issue_scheduler #(.DEPTH(DEPTH)) dut (
      .clk(clk), .n_rst(n_rst),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_is_store(alloc_is_store),
      .alloc_use_ra(alloc_use_ra), .alloc_ra_addr(alloc_ra_addr), .alloc_ra_rdy(alloc_ra_rdy),
      .alloc_use_rt(alloc_use_rt), .alloc_rt_addr(alloc_rt_addr), .alloc_rt_rdy(alloc_rt_rdy),
      .alloc_use_rw(alloc_use_rw), .alloc_rw_addr(alloc_rw_addr), .alloc_mem_op(alloc_mem_op),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_op(dc_req_op),
      .dc_req_ra_addr(dc_req_ra_addr), .dc_req_rt_addr(dc_req_rt_addr),
      .dc_req_rw_addr(dc_req_rw_addr), .dc_req_use_rw(dc_req_use_rw),
      .dc_resp_valid(dc_resp_valid),
      .done_valid(done_valid), .done_rw_addr(done_rw_addr), .done_use_rw(done_use_rw),
      .empty(empty)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   // Reference model: ops in age order; issued ops linger until they reach the front.
   typedef struct {
      bit          st;
      bit [RW-1:0] ra, rt, rw;
      bit          ra_ok, rt_ok, use_rw, issued;
      MemOp        op;
   } ent_t;

   ent_t        mq[$];
   int          m_phase;        // 0 idle, 1 request, 2 waiting, 3 draining
   MemOp        m_op;
   bit [RW-1:0] m_ra, m_rt, m_rw, m_done_rw;
   bit          m_use_rw, m_done, m_done_use;

   int done_log[$];
   int acc_log[$];

   task automatic model_reset();
      mq.delete();
      m_phase = 0; m_done = 0; m_done_rw = '0; m_done_use = 0;
      m_op = MEM_LB; m_ra = '0; m_rt = '0; m_rw = '0; m_use_rw = 0;
   endtask

   task automatic model_step();
      int   sel;
      int   old_size;
      bit   blocked, reclaim;
      ent_t e;
      sel = -1;
      if (m_phase == 0 && !flush) begin
         for (int i = 0; i < mq.size(); i++) begin
            if (sel < 0 && !mq[i].issued && mq[i].ra_ok && mq[i].rt_ok) begin
               blocked = 0;
               for (int j = 0; j < i; j++)
                  if (!mq[j].issued && (mq[i].st || mq[j].st)) blocked = 1;
               if (!blocked) sel = i;
            end
         end
      end
      m_done = (m_phase == 2) && dc_resp_valid && !flush;
      if (m_done) begin m_done_rw = m_rw; m_done_use = m_use_rw; end
      case (m_phase)
         0: if (sel >= 0) m_phase = 1;
         1: if (flush) m_phase = dc_req_ready ? 3 : 0; else if (dc_req_ready) m_phase = 2;
         2: if (flush) m_phase = dc_resp_valid ? 0 : 3; else if (dc_resp_valid) m_phase = 0;
         default: if (dc_resp_valid) m_phase = 0;
      endcase
      if (flush) begin
         mq.delete();
      end else begin
         old_size = mq.size();
         reclaim  = (old_size > 0) && mq[0].issued;
         if (wb_valid) begin
            foreach (mq[i]) begin
               if (mq[i].ra == wb_addr) mq[i].ra_ok = 1;
               if (mq[i].rt == wb_addr) mq[i].rt_ok = 1;
            end
         end
         if (sel >= 0) begin
            m_op = mq[sel].op; m_ra = mq[sel].ra; m_rt = mq[sel].rt;
            m_rw = mq[sel].rw; m_use_rw = mq[sel].use_rw;
            mq[sel].issued = 1;
         end
         if (reclaim) void'(mq.pop_front());
         if (alloc_valid && old_size < DEPTH) begin
            e.st = alloc_is_store; e.ra = alloc_ra_addr; e.rt = alloc_rt_addr;
            e.rw = alloc_rw_addr; e.use_rw = alloc_use_rw; e.op = alloc_mem_op; e.issued = 0;
            e.ra_ok = !alloc_use_ra || alloc_ra_rdy || (wb_valid && wb_addr == alloc_ra_addr);
            e.rt_ok = !alloc_use_rt || alloc_rt_rdy || (wb_valid && wb_addr == alloc_rt_addr);
            mq.push_back(e);
         end
      end
   endtask

   task automatic tick();
      model_step();
      if (dc_req_valid && dc_req_ready) acc_log.push_back(int'(dc_req_op));
      @(posedge clk); #1;
      if (done_valid) done_log.push_back(int'(done_rw_addr));
   endtask

   task automatic clear_inputs();
      alloc_valid = 0; alloc_is_store = 0; alloc_use_ra = 0; alloc_ra_addr = '0; alloc_ra_rdy = 0;
      alloc_use_rt = 0; alloc_rt_addr = '0; alloc_rt_rdy = 0; alloc_use_rw = 0; alloc_rw_addr = '0;
      alloc_mem_op = MEM_LB; wb_valid = 0; wb_addr = '0; flush = 0;
      dc_req_ready = 0; dc_resp_valid = 0;
   endtask

   task automatic set_alloc(input bit st, input bit ua, input int ra, input bit rra,
                            input bit ut, input int rt, input bit rrt,
                            input bit uw, input int rw, input MemOp op);
      alloc_valid = 1; alloc_is_store = st;
      alloc_use_ra = ua; alloc_ra_addr = RW'(ra); alloc_ra_rdy = rra;
      alloc_use_rt = ut; alloc_rt_addr = RW'(rt); alloc_rt_rdy = rrt;
      alloc_use_rw = uw; alloc_rw_addr = RW'(rw); alloc_mem_op = op;
   endtask

   task automatic do_reset();
      clear_inputs();
      n_rst = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_rst = 1;
      model_reset();
      done_log.delete();
      acc_log.delete();
   endtask

   task automatic test_reset();
      do_reset();
      set_alloc(0, 1, 1, 1, 1, 2, 1, 1, 17, MEM_LW);
      tick();
      alloc_valid = 0;
      tick();
      total++; if (dc_req_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_req: got %0b want 1", dc_req_valid); end
      set_alloc(0, 0, 0, 0, 0, 0, 0, 1, 18, MEM_LB);
      #2 n_rst = 0;
      #1;
      total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready: got %0b want 1", alloc_ready); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %0b want 1", empty); end
      total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %0b want 0", dc_req_valid); end
      total++; if (dc_req_rw_addr !== '0) begin bad++; $display("FAIL reset_req_rw: got %0d want 0", dc_req_rw_addr); end
      total++; if (done_valid !== 1'b0) begin bad++; $display("FAIL reset_done_valid: got %0b want 0", done_valid); end
      total++; if (done_rw_addr !== '0) begin bad++; $display("FAIL reset_done_rw: got %0d want 0", done_rw_addr); end
      do_reset();
   endtask

   task automatic test_fill_order();
      do_reset();
      dc_req_ready = 1;
      set_alloc(0, 1, 1, 1, 0, 0, 0, 1, 9, MEM_LW);
      tick();
      alloc_valid = 0;
      repeat (4) tick();
      for (int i = 0; i < 4; i++) begin
         total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d: got %0b want 1", i, alloc_ready); end
         set_alloc(0, 1, 2, 1, 1, 3, 1, 1, 10 + i, MEM_LW);
         tick();
      end
      alloc_valid = 0;
      total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL fill_full: got %0b want 0", alloc_ready); end
      dc_resp_valid = 1;
      for (int i = 0; i < 80 && done_log.size() < 5; i++) tick();
      total++; if (done_log.size() != 5) begin bad++; $display("FAIL fill_done_count: got %0d want 5", done_log.size()); end
      for (int i = 0; i < done_log.size() && i < 5; i++) begin
         total++; if (done_log[i] != 9 + i) begin bad++; $display("FAIL fill_done_order_%0d: got %0d want %0d", i, done_log[i], 9 + i); end
      end
   endtask

   task automatic test_store_first();
      do_reset();
      dc_req_ready = 1; dc_resp_valid = 1;
      set_alloc(1, 1, 5, 0, 1, 3, 1, 0, 0, MEM_SW);
      tick();
      set_alloc(0, 1, 2, 1, 0, 0, 0, 1, 20, MEM_LW);
      tick();
      alloc_valid = 0;
      repeat (8) tick();
      total++; if (acc_log.size() != 0) begin bad++; $display("FAIL store_load_held: got %0d issued want 0", acc_log.size()); end
      wb_valid = 1; wb_addr = RW'(5);
      tick();
      wb_valid = 0;
      for (int i = 0; i < 40 && done_log.size() < 2; i++) tick();
      total++; if (acc_log.size() != 2) begin bad++; $display("FAIL store_issue_count: got %0d want 2", acc_log.size()); end
      if (acc_log.size() == 2) begin
         total++; if (acc_log[0] != int'(MEM_SW)) begin bad++; $display("FAIL store_issue_first: got %0d want %0d", acc_log[0], int'(MEM_SW)); end
         total++; if (acc_log[1] != int'(MEM_LW)) begin bad++; $display("FAIL store_load_second: got %0d want %0d", acc_log[1], int'(MEM_LW)); end
      end
      total++; if (done_log.size() != 2) begin bad++; $display("FAIL store_done_count: got %0d want 2", done_log.size()); end
      else begin
         total++; if (done_log[1] != 20) begin bad++; $display("FAIL store_load_done_rw: got %0d want 20", done_log[1]); end
      end
   endtask

   task automatic test_load_bypass();
      do_reset();
      dc_req_ready = 1; dc_resp_valid = 1;
      set_alloc(0, 0, 0, 0, 1, 7, 0, 1, 21, MEM_LH);
      tick();
      set_alloc(0, 1, 4, 1, 0, 0, 0, 1, 22, MEM_LB);
      tick();
      alloc_valid = 0;
      repeat (10) tick();
      total++; if (done_log.size() != 1) begin bad++; $display("FAIL bypass_first_count: got %0d want 1", done_log.size()); end
      else begin
         total++; if (done_log[0] != 22) begin bad++; $display("FAIL bypass_first_rw: got %0d want 22", done_log[0]); end
      end
      wb_valid = 1; wb_addr = RW'(7);
      tick();
      wb_valid = 0;
      for (int i = 0; i < 30 && done_log.size() < 2; i++) tick();
      total++; if (done_log.size() != 2) begin bad++; $display("FAIL bypass_second_count: got %0d want 2", done_log.size()); end
      else begin
         total++; if (done_log[1] != 21) begin bad++; $display("FAIL bypass_second_rw: got %0d want 21", done_log[1]); end
      end
   endtask

   task automatic test_req_stall();
      do_reset();
      set_alloc(0, 1, 4, 1, 1, 6, 1, 1, 23, MEM_LH);
      tick();
      set_alloc(0, 1, 1, 1, 0, 0, 0, 1, 24, MEM_LW);
      tick();
      alloc_valid = 0;
      for (int i = 0; i < 10 && !dc_req_valid; i++) tick();
      total++; if (dc_req_valid !== 1'b1) begin bad++; $display("FAIL stall_req_seen: got %0b want 1", dc_req_valid); end
      total++; if (dc_req_op !== MEM_LH) begin bad++; $display("FAIL stall_req_op: got %0d want %0d", int'(dc_req_op), int'(MEM_LH)); end
      total++; if (dc_req_ra_addr !== RW'(4)) begin bad++; $display("FAIL stall_req_ra: got %0d want 4", dc_req_ra_addr); end
      total++; if (dc_req_rt_addr !== RW'(6)) begin bad++; $display("FAIL stall_req_rt: got %0d want 6", dc_req_rt_addr); end
      total++; if (dc_req_use_rw !== 1'b1) begin bad++; $display("FAIL stall_req_use_rw: got %0b want 1", dc_req_use_rw); end
      for (int i = 0; i < 10; i++) begin
         tick();
         total++; if (dc_req_valid !== 1'b1 || dc_req_rw_addr !== RW'(23)) begin
            bad++; $display("FAIL stall_hold_%0d: got valid=%0b rw=%0d want valid=1 rw=23", i, dc_req_valid, dc_req_rw_addr);
         end
      end
      dc_req_ready = 1; dc_resp_valid = 1;
      for (int i = 0; i < 40 && done_log.size() < 2; i++) tick();
      total++; if (done_log.size() != 2) begin bad++; $display("FAIL stall_done_count: got %0d want 2", done_log.size()); end
      else begin
         total++; if (done_log[0] != 23 || done_log[1] != 24) begin bad++; $display("FAIL stall_done_order: got %0d,%0d want 23,24", done_log[0], done_log[1]); end
      end
   endtask

   task automatic test_flush_wait();
      do_reset();
      dc_req_ready = 1;
      set_alloc(0, 1, 1, 1, 0, 0, 0, 1, 25, MEM_LW);
      tick();
      alloc_valid = 0;
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         set_alloc(0, 1, 2, 1, 0, 0, 0, 1, 26 + i, MEM_LB);
         tick();
      end
      alloc_valid = 0;
      total++; if (empty !== 1'b0) begin bad++; $display("FAIL flush_pre_empty: got %0b want 0", empty); end
      flush = 1;
      tick();
      flush = 0;
      total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL flush_alloc_ready: got %0b want 1", alloc_ready); end
      total++; if (empty !== 1'b0) begin bad++; $display("FAIL flush_drain_empty: got %0b want 0", empty); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL flush_no_req_%0d: got %0b want 0", i, dc_req_valid); end
      end
      dc_resp_valid = 1;
      tick();
      dc_resp_valid = 0;
      repeat (4) tick();
      total++; if (done_log.size() != 0) begin bad++; $display("FAIL flush_no_done: got %0d want 0", done_log.size()); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL flush_post_empty: got %0b want 1", empty); end
      total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL flush_post_req: got %0b want 0", dc_req_valid); end
   endtask

   task automatic test_wb_same_cycle();
      do_reset();
      set_alloc(0, 1, 9, 0, 0, 0, 0, 1, 30, MEM_LHU);
      wb_valid = 1; wb_addr = RW'(9);
      tick();
      alloc_valid = 0; wb_valid = 0;
      total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL wbsame_n1: got %0b want 0", dc_req_valid); end
      tick();
      total++; if (dc_req_valid !== 1'b1) begin bad++; $display("FAIL wbsame_n2: got %0b want 1", dc_req_valid); end
      total++; if (dc_req_rw_addr !== RW'(30)) begin bad++; $display("FAIL wbsame_rw: got %0d want 30", dc_req_rw_addr); end
   endtask

   task automatic test_random();
      bit m_empty;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         alloc_valid    = ($urandom_range(0, 99) < 55);
         alloc_is_store = ($urandom_range(0, 99) < 30);
         alloc_use_ra   = $urandom_range(0, 1);
         alloc_ra_addr  = RW'($urandom_range(0, 7));
         alloc_ra_rdy   = $urandom_range(0, 1);
         alloc_use_rt   = $urandom_range(0, 1);
         alloc_rt_addr  = RW'($urandom_range(0, 7));
         alloc_rt_rdy   = $urandom_range(0, 1);
         alloc_use_rw   = $urandom_range(0, 1);
         alloc_rw_addr  = RW'($urandom_range(0, 31));
         alloc_mem_op   = MemOp'($urandom_range(0, 7));
         wb_valid       = ($urandom_range(0, 99) < 40);
         wb_addr        = RW'($urandom_range(0, 7));
         flush          = ($urandom_range(0, 99) < 2);
         dc_req_ready   = ($urandom_range(0, 99) < 60);
         dc_resp_valid  = !flush && ($urandom_range(0, 99) < 40);
         tick();
         m_empty = (m_phase == 0);
         foreach (mq[i]) if (!mq[i].issued) m_empty = 0;
         total++; if (alloc_ready !== (mq.size() < DEPTH)) begin bad++; $display("FAIL rnd_alloc_ready c%0d: got %0b want %0b", c, alloc_ready, mq.size() < DEPTH); end
         total++; if (empty !== m_empty) begin bad++; $display("FAIL rnd_empty c%0d: got %0b want %0b", c, empty, m_empty); end
         total++; if (dc_req_valid !== (m_phase == 1)) begin bad++; $display("FAIL rnd_req_valid c%0d: got %0b want %0b", c, dc_req_valid, m_phase == 1); end
         if (m_phase == 1) begin
            total++;
            if (dc_req_op !== m_op || dc_req_ra_addr !== m_ra || dc_req_rt_addr !== m_rt ||
                dc_req_rw_addr !== m_rw || dc_req_use_rw !== m_use_rw) begin
               bad++;
               $display("FAIL rnd_req_fields c%0d: got op=%0d ra=%0d rt=%0d rw=%0d u=%0b want op=%0d ra=%0d rt=%0d rw=%0d u=%0b",
                        c, int'(dc_req_op), dc_req_ra_addr, dc_req_rt_addr, dc_req_rw_addr, dc_req_use_rw,
                        int'(m_op), m_ra, m_rt, m_rw, m_use_rw);
            end
         end
         total++; if (done_valid !== m_done) begin bad++; $display("FAIL rnd_done_valid c%0d: got %0b want %0b", c, done_valid, m_done); end
         if (m_done) begin
            total++;
            if (done_rw_addr !== m_done_rw || done_use_rw !== m_done_use) begin
               bad++; $display("FAIL rnd_done_fields c%0d: got rw=%0d u=%0b want rw=%0d u=%0b", c, done_rw_addr, done_use_rw, m_done_rw, m_done_use);
            end
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      n_rst = 0;
      model_reset();
      test_reset();
      test_fill_order();
      test_store_first();
      test_load_bypass();
      test_req_stall();
      test_flush_wait();
      test_wb_same_cycle();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
